alu_op_sequencer: RTL and testbench

//  Multi-cycle sequencer in front of the combinational 32-bit ALU (5-bit opcode, NZCV outputs).
//  - Accepts one op per valid/ready handshake and drives the ALU from registered operands.
//  - Owns the architectural NZCV flag register and supplies the ALU carry-in from it.
//  - Returns result plus writeback control to the register-file stage via valid/ready.

---
 rtl/alu_op_sequencer_pkg.sv | 48 ++++
 rtl/alu_op_sequencer_decode.sv | 71 +++++++
 rtl/alu_op_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module  : alu_op_sequencer_pkg
// Brief   : Opcode map, FSM encoding and NZCV flag layout for the ALU sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_op_sequencer_pkg;

    // ALU opcode map
    localparam logic [4:0] c_op_and    = 5'b00000;
    localparam logic [4:0] c_op_eor    = 5'b00001;
    localparam logic [4:0] c_op_sub    = 5'b00010;
    localparam logic [4:0] c_op_rsb    = 5'b00011;
    localparam logic [4:0] c_op_add    = 5'b00100;
    localparam logic [4:0] c_op_adc    = 5'b00101;
    localparam logic [4:0] c_op_sbc    = 5'b00110;
    localparam logic [4:0] c_op_rsc    = 5'b00111;
    localparam logic [4:0] c_op_tst    = 5'b01000;
    localparam logic [4:0] c_op_teq    = 5'b01001;
    localparam logic [4:0] c_op_cmp    = 5'b01010;
    localparam logic [4:0] c_op_cmn    = 5'b01011;
    localparam logic [4:0] c_op_orr    = 5'b01100;
    localparam logic [4:0] c_op_mov    = 5'b01101;
    localparam logic [4:0] c_op_bic    = 5'b01110;
    localparam logic [4:0] c_op_mvn    = 5'b01111;
    localparam logic [4:0] c_op_aadd   = 5'b10000;
    localparam logic [4:0] c_op_asub   = 5'b10001;
    localparam logic [4:0] c_op_aadd4  = 5'b10010;
    localparam logic [4:0] c_op_asub4  = 5'b10011;
    localparam logic [4:0] c_op_asubb4 = 5'b10100;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_exec = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    localparam int c_fn = 3;
    localparam int c_fz = 2;
    localparam int c_fc = 1;
    localparam int c_fv = 0;

    localparam logic [3:0] c_mask_none = 4'b0000;
    localparam logic [3:0] c_mask_nzc  = 4'b1110;
    localparam logic [3:0] c_mask_all  = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/alu_op_sequencer_decode.sv
//------------------------------------------------------------------------------
// Module  : alu_op_sequencer_decode
// Brief   : Maps a requested opcode to ALU opcode, writeback and flag controls.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_op_sequencer_decode
    import alu_op_sequencer_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic [OPC_W-1:0] i_opcode,
    output logic [OPC_W-1:0] o_alu_opcode,
    output logic             o_wb_en,
    output logic             o_err,
    output logic [3:0]       o_flag_mask,
    output logic             o_force_s
);

    always_comb begin
        o_alu_opcode = i_opcode;
        o_wb_en      = 1'b1;
        o_err        = 1'b0;
        o_flag_mask  = c_mask_nzc;
        o_force_s    = 1'b0;
        case (i_opcode)
            c_op_and, c_op_eor, c_op_orr, c_op_mov, c_op_bic, c_op_mvn: begin
                o_flag_mask = c_mask_nzc;
            end
            c_op_sub, c_op_rsb, c_op_add, c_op_adc, c_op_sbc, c_op_rsc: begin
                o_flag_mask = c_mask_all;
            end
            // Compare/test ops reuse the base ALU function and always set flags
            c_op_tst: begin
                o_alu_opcode = c_op_and;
                o_wb_en      = 1'b0;
                o_force_s    = 1'b1;
            end
            c_op_teq: begin
                o_alu_opcode = c_op_eor;
                o_wb_en      = 1'b0;
                o_force_s    = 1'b1;
            end
            c_op_cmp: begin
                o_alu_opcode = c_op_sub;
                o_wb_en      = 1'b0;
                o_force_s    = 1'b1;
                o_flag_mask  = c_mask_all;
            end
            c_op_cmn: begin
                o_alu_opcode = c_op_add;
                o_wb_en      = 1'b0;
                o_force_s    = 1'b1;
                o_flag_mask  = c_mask_all;
            end
            c_op_aadd, c_op_asub, c_op_aadd4, c_op_asub4, c_op_asubb4: begin
                o_flag_mask = c_mask_none;
            end
            default: begin
                o_alu_opcode = c_op_aadd;
                o_wb_en      = 1'b0;
                o_err        = 1'b1;
                o_flag_mask  = c_mask_none;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
//------------------------------------------------------------------------------
// Module  : alu_op_sequencer
// Brief   : IDLE/EXEC/RESP sequencer around an external ALU with NZCV register.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OPC_W  = 5,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OPC_W-1:0]  req_opcode,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic              req_s,
    input  logic [REG_W-1:0]  req_rd,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic              alu_carry,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_v,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_rd,
    output logic              wb_en,
    output logic              wb_err,
    input  logic              flag_wr_en,
    input  logic [3:0]        flag_wr_data,
    output logic [3:0]        flags,
    output logic [CNT_W-1:0]  op_count
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [OPC_W-1:0]  r_opc;
    logic [REG_W-1:0]  r_rd;
    logic              r_wb_en;
    logic              r_err;
    logic [3:0]        r_commit_mask;
    logic [DATA_W-1:0] r_wb_data;
    logic [3:0]        r_flags;
    logic [3:0]        w_flags_nxt;
    logic [CNT_W-1:0]  r_count;

    logic [OPC_W-1:0]  w_dec_opc;
    logic              w_dec_wb_en;
    logic              w_dec_err;
    logic [3:0]        w_dec_mask;
    logic              w_dec_force_s;
    logic              w_accept;

    alu_op_sequencer_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .i_opcode     (req_opcode),
        .o_alu_opcode (w_dec_opc),
        .o_wb_en      (w_dec_wb_en),
        .o_err        (w_dec_err),
        .o_flag_mask  (w_dec_mask),
        .o_force_s    (w_dec_force_s)
    );

    assign req_ready = (r_state == c_st_idle);
    assign wb_valid  = (r_state == c_st_resp);
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (req_valid) w_state_nxt = c_st_exec;
            c_st_exec: w_state_nxt = c_st_resp;
            c_st_resp: if (wb_ready) w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // The commit mask already folds in the set-flags decision, so EXEC only
    // merges masked ALU flags; an external load overrides all four bits.
    always_comb begin
        w_flags_nxt = r_flags;
        if (r_state == c_st_exec) begin
            w_flags_nxt = (r_flags & ~r_commit_mask) |
                          ({alu_n, alu_z, alu_c, alu_v} & r_commit_mask);
        end
        if (flag_wr_en) begin
            w_flags_nxt = flag_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_a           <= '0;
            r_b           <= '0;
            r_opc         <= '0;
            r_rd          <= '0;
            r_wb_en       <= 1'b0;
            r_err         <= 1'b0;
            r_commit_mask <= c_mask_none;
            r_wb_data     <= '0;
            r_flags       <= 4'b0000;
            r_count       <= '0;
        end else begin
            r_flags <= w_flags_nxt;
            if (w_accept) begin
                r_a           <= req_a;
                r_b           <= req_b;
                r_opc         <= w_dec_opc;
                r_rd          <= req_rd;
                r_wb_en       <= w_dec_wb_en;
                r_err         <= w_dec_err;
                r_commit_mask <= (req_s || w_dec_force_s) ? w_dec_mask : c_mask_none;
            end
            if (r_state == c_st_exec) begin
                r_wb_data <= alu_result;
            end
            if ((r_state == c_st_resp) && wb_ready) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_opcode = r_opc;
    assign alu_carry  = r_flags[c_fc];
    assign wb_data    = r_wb_data;
    assign wb_rd      = r_rd;
    assign wb_en      = r_wb_en;
    assign wb_err     = r_err;
    assign flags      = r_flags;
    assign op_count   = r_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
//------------------------------------------------------------------------------
// Module  : tb_alu_op_sequencer
// Brief   : Directed table plus randomized ops against a behavioural ALU/flag model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_op_sequencer;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic [4:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [3:0]  pre;
        logic [4:0]  aluop;
        logic [31:0] data;
        logic        en;
        logic        err;
        logic [3:0]  flg;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic [4:0]       req_opcode;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic             req_s;
    logic [3:0]       req_rd;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [4:0]       alu_opcode;
    logic             alu_carry;
    logic [31:0]      alu_result;
    logic             alu_n;
    logic             alu_z;
    logic             alu_c;
    logic             alu_v;
    logic             wb_valid;
    logic             wb_ready;
    logic [31:0]      wb_data;
    logic [3:0]       wb_rd;
    logic             wb_en;
    logic             wb_err;
    logic             flag_wr_en;
    logic [3:0]       flag_wr_data;
    logic [3:0]       flags;
    logic [CNT_W-1:0] op_count;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [3:0]       m_flags;
    logic [CNT_W-1:0] m_count;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .DATA_W (32),
        .OPC_W  (5),
        .REG_W  (4),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_opcode   (req_opcode),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_s        (req_s),
        .req_rd       (req_rd),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_carry    (alu_carry),
        .alu_result   (alu_result),
        .alu_n        (alu_n),
        .alu_z        (alu_z),
        .alu_c        (alu_c),
        .alu_v        (alu_v),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .wb_en        (wb_en),
        .wb_err       (wb_err),
        .flag_wr_en   (flag_wr_en),
        .flag_wr_data (flag_wr_data),
        .flags        (flags),
        .op_count     (op_count)
    );

    // Behavioural ALU: returns {N,Z,C,V,result}; logical/address ops pass carry-in through as C
    function automatic logic [35:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic cin);
        logic [32:0] sum;
        logic [31:0] x, y, r;
        logic        ci, c, v, arith;
        x = 32'd0; y = 32'd0; ci = 1'b0; r = 32'd0; c = cin; v = 1'b0; arith = 1'b1;
        case (op)
            5'd2:  begin x = a; y = ~b; ci = 1'b1; end
            5'd3:  begin x = b; y = ~a; ci = 1'b1; end
            5'd4:  begin x = a; y = b;  ci = 1'b0; end
            5'd5:  begin x = a; y = b;  ci = cin;  end
            5'd6:  begin x = a; y = ~b; ci = cin;  end
            5'd7:  begin x = b; y = ~a; ci = cin;  end
            default: arith = 1'b0;
        endcase
        if (arith) begin
            sum = {1'b0, x} + {1'b0, y} + {32'd0, ci};
            r   = sum[31:0];
            c   = sum[32];
            v   = (x[31] == y[31]) && (r[31] != x[31]);
        end else begin
            case (op)
                5'd0:  r = a & b;
                5'd1:  r = a ^ b;
                5'd12: r = a | b;
                5'd13: r = b;
                5'd14: r = a & ~b;
                5'd15: r = ~b;
                5'd16: r = a + b;
                5'd17: r = a - b;
                5'd18: r = a + 32'd4;
                5'd19: r = a - 32'd4;
                5'd20: r = a - (b << 2);
                default: r = 32'd0;
            endcase
        end
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    logic [35:0] alu_out;
    always_comb alu_out = alu_model(alu_opcode, alu_a, alu_b, alu_carry);
    assign {alu_n, alu_z, alu_c, alu_v, alu_result} = alu_out;

    function automatic vec_t ref_op(input logic [4:0] opc, input logic [31:0] a,
                                    input logic [31:0] b, input logic s, input logic [3:0] f);
        vec_t        v;
        logic [35:0] o;
        logic        commit, keepv;
        v.opc = opc; v.a = a; v.b = b; v.s = s; v.pre = f;
        v.err = 1'b0; v.en = 1'b1; v.aluop = opc; commit = 1'b0; keepv = 1'b1;
        if (opc <= 5'd7 || (opc >= 5'd12 && opc <= 5'd15)) begin
            commit = s;
            keepv  = (opc <= 5'd1) || (opc >= 5'd12);
        end else if (opc <= 5'd11) begin
            case (opc)
                5'd8:    v.aluop = 5'd0;
                5'd9:    v.aluop = 5'd1;
                5'd10:   v.aluop = 5'd2;
                default: v.aluop = 5'd4;
            endcase
            v.en = 1'b0; commit = 1'b1; keepv = (opc <= 5'd9);
        end else if (opc > 5'd20) begin
            v.aluop = 5'd16; v.en = 1'b0; v.err = 1'b1;
        end
        o      = alu_model(v.aluop, a, b, f[1]);
        v.data = o[31:0];
        v.flg  = f;
        if (commit) begin
            v.flg[3:1] = o[35:33];
            if (!keepv) v.flg[0] = o[32];
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_flags(input logic [3:0] f);
        flag_wr_en   = 1'b1;
        flag_wr_data = f;
        tick();
        flag_wr_en   = 1'b0;
        m_flags      = f;
        chk("flag_load", {28'd0, flags}, {28'd0, f});
    endtask

    task automatic run_op(input vec_t v, input logic [3:0] rd, input int stall,
                          input bit hold, input bit fw, input logic [3:0] fwd);
        logic [3:0]       eflags;
        logic [CNT_W-1:0] cnt0;
        eflags = fw ? fwd : v.flg;
        cnt0   = m_count;
        req_opcode = v.opc; req_a = v.a; req_b = v.b; req_s = v.s; req_rd = rd;
        req_valid  = 1'b1;
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        // Scrambled request fields must not be captured outside IDLE
        req_valid  = hold;
        req_a = ~v.a; req_b = ~v.b; req_opcode = ~v.opc; req_s = ~v.s; req_rd = ~rd;
        chk("exec_alu_opcode", {27'd0, alu_opcode}, {27'd0, v.aluop});
        chk("exec_alu_a", alu_a, v.a);
        chk("exec_alu_b", alu_b, v.b);
        chk("exec_alu_carry", {31'd0, alu_carry}, {31'd0, v.pre[1]});
        chk("exec_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("exec_req_ready", {31'd0, req_ready}, 32'd0);
        if (fw) begin
            flag_wr_en = 1'b1; flag_wr_data = fwd;
        end
        tick();
        flag_wr_en = 1'b0;
        chk("resp_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("resp_wb_data", wb_data, v.data);
        chk("resp_wb_en", {31'd0, wb_en}, {31'd0, v.en});
        chk("resp_wb_err", {31'd0, wb_err}, {31'd0, v.err});
        chk("resp_wb_rd", {28'd0, wb_rd}, {28'd0, rd});
        chk("resp_flags", {28'd0, flags}, {28'd0, eflags});
        chk("resp_op_count", {24'd0, op_count}, {24'd0, cnt0});
        for (int k = 0; k < stall; k++) begin
            tick();
            chk("stall_wb_valid", {31'd0, wb_valid}, 32'd1);
            chk("stall_wb_data", wb_data, v.data);
            chk("stall_alu_a", alu_a, v.a);
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
            chk("stall_op_count", {24'd0, op_count}, {24'd0, cnt0});
        end
        req_valid = 1'b0;
        wb_ready  = 1'b1;
        tick();
        wb_ready  = 1'b0;
        m_count   = m_count + 1'b1;
        m_flags   = eflags;
        chk("done_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("done_req_ready", {31'd0, req_ready}, 32'd1);
        chk("done_op_count", {24'd0, op_count}, {24'd0, m_count});
        chk("done_flags", {28'd0, flags}, {28'd0, m_flags});
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    vec_t tbl [12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        //            opc       a             b             s     pre      aluop     data          en    err   flg
        tbl[0]  = '{5'b00100, 32'h7FFFFFFF, 32'h00000001, 1'b1, 4'b0000, 5'b00100, 32'h80000000, 1'b1, 1'b0, 4'b1001};
        tbl[1]  = '{5'b01010, 32'h00000005, 32'h00000005, 1'b0, 4'b0000, 5'b00010, 32'h00000000, 1'b0, 1'b0, 4'b0110};
        tbl[2]  = '{5'b00010, 32'h00000009, 32'h00000003, 1'b0, 4'b1111, 5'b00010, 32'h00000006, 1'b1, 1'b0, 4'b1111};
        tbl[3]  = '{5'b00101, 32'h00000001, 32'h00000001, 1'b0, 4'b0010, 5'b00101, 32'h00000003, 1'b1, 1'b0, 4'b0010};
        tbl[4]  = '{5'b11000, 32'h00000001, 32'h00000002, 1'b1, 4'b0101, 5'b10000, 32'h00000003, 1'b0, 1'b1, 4'b0101};
        tbl[5]  = '{5'b00000, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, 4'b0001, 5'b00000, 32'h00000000, 1'b1, 1'b0, 4'b0101};
        tbl[6]  = '{5'b01000, 32'h80000000, 32'h80000000, 1'b0, 4'b0011, 5'b00000, 32'h80000000, 1'b0, 1'b0, 4'b1011};
        tbl[7]  = '{5'b01011, 32'hFFFFFFFF, 32'h00000001, 1'b0, 4'b0000, 5'b00100, 32'h00000000, 1'b0, 1'b0, 4'b0110};
        tbl[8]  = '{5'b10100, 32'h00000100, 32'h00000010, 1'b1, 4'b1100, 5'b10100, 32'h000000C0, 1'b1, 1'b0, 4'b1100};
        tbl[9]  = '{5'b01001, 32'h000000FF, 32'h000000FF, 1'b0, 4'b1001, 5'b00001, 32'h00000000, 1'b0, 1'b0, 4'b0101};
        tbl[10] = '{5'b00011, 32'h00000005, 32'h00000003, 1'b1, 4'b0000, 5'b00011, 32'hFFFFFFFE, 1'b1, 1'b0, 4'b1000};
        tbl[11] = '{5'b01111, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 5'b01111, 32'hFFFFFFFF, 1'b1, 1'b0, 4'b1000};

        reset_n = 1'b0; req_valid = 1'b0; req_opcode = '0; req_a = '0; req_b = '0;
        req_s = 1'b0; req_rd = '0; wb_ready = 1'b0; flag_wr_en = 1'b0; flag_wr_data = '0;
        m_flags = '0; m_count = '0;
        tick(); tick();
        reset_n = 1'b1;

        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_en", {30'd0, wb_en, wb_err}, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk("rst_op_count", {24'd0, op_count}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);

        for (int i = 0; i < 12; i++) begin
            load_flags(tbl[i].pre);
            run_op(tbl[i], 4'(i), (i == 0) ? 5 : i % 3, (i % 2) == 1, 1'b0, 4'b0000);
        end

        // External flag load in the same edge as a flag-setting CMP commit
        run_op(ref_op(5'b01010, 32'd5, 32'd5, 1'b0, m_flags), 4'd3, 0, 1'b0, 1'b1, 4'b1010);

        // Reset while an op sits in EXEC: op is discarded, flags and count cleared
        load_flags(4'b1111);
        req_opcode = 5'b01010; req_a = 32'd1; req_b = 32'd2; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        reset_n   = 1'b0;
        tick();
        reset_n   = 1'b1;
        m_flags   = '0;
        m_count   = '0;
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("mid_rst_flags", {28'd0, flags}, 32'd0);
        chk("mid_rst_op_count", {24'd0, op_count}, 32'd0);
        chk("mid_rst_alu_opcode", {27'd0, alu_opcode}, 32'd0);
        tick();
        chk("mid_rst_idle_hold", {31'd0, req_ready}, 32'd1);

        // Enough random ops to wrap the counter past its all-ones value
        for (int n = 0; n < 270; n++) begin
            vec_t v;
            v = ref_op(5'($urandom_range(0, 31)), pick_operand(), pick_operand(),
                       1'($urandom_range(0, 1)), m_flags);
            run_op(v, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                   4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
